// File: rtl/ctrlset_gen.sv
// rtl/ctrlset_gen.sv - control-set generator for an enable/sync-set/sync-clear flop bank (optional CTRLSET_GEN_SETQ_EN queues a set behind a clear)
module ctrlset_gen #(
    parameter int DIV   = 4,
    parameter int PULSE = 2
) (
    input  logic clk,
    input  logic R,
    input  logic run,
    input  logic clr_req,
    input  logic set_req,
    output logic E,
    output logic L,
    output logic H,
    output logic busy
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW = (PULSE > 1) ? $clog2(PULSE) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [PW-1:0] PCNT_MAX = PW'(PULSE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SET   = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] pcnt;
`ifdef CTRLSET_GEN_SETQ_EN
    logic          pend;
`endif

    // Single FSM: enable divider while idle, timed active-low clear/set strobes otherwise
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            // Reset doubles as a clear strobe that lasts PULSE cycles past release
            state <= CLEAR;
            pcnt  <= PCNT_MAX;
            cnt   <= '0;
            E     <= 1'b0;
            L     <= 1'b0;
            H     <= 1'b1;
            busy  <= 1'b1;
`ifdef CTRLSET_GEN_SETQ_EN
            pend  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        // Clear wins over a simultaneous set request
                        state <= CLEAR;
                        pcnt  <= PCNT_MAX;
                        L     <= 1'b0;
                        E     <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else if (set_req) begin
                        state <= SET;
                        pcnt  <= PCNT_MAX;
                        H     <= 1'b0;
                        E     <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else if (run && (cnt == CNT_MAX)) begin
                        E   <= 1'b1;
                        cnt <= '0;
                    end else if (run) begin
                        E   <= 1'b0;
                        cnt <= cnt + 1'b1;
                    end else begin
                        // Gaps in run hold the count so the period stretches
                        E <= 1'b0;
                    end
                end

                CLEAR: begin
`ifdef CTRLSET_GEN_SETQ_EN
                    if (set_req) begin
                        pend <= 1'b1;
                    end
`endif
                    if (clr_req) begin
                        pcnt <= PCNT_MAX;
                    end else if (pcnt == '0) begin
`ifdef CTRLSET_GEN_SETQ_EN
                        if (pend || set_req) begin
                            // Hand straight over to a set strobe; L and H swap on one edge
                            state <= SET;
                            pcnt  <= PCNT_MAX;
                            L     <= 1'b1;
                            H     <= 1'b0;
                            pend  <= 1'b0;
                        end else begin
                            state <= IDLE;
                            L     <= 1'b1;
                            busy  <= 1'b0;
                        end
`else
                        state <= IDLE;
                        L     <= 1'b1;
                        busy  <= 1'b0;
`endif
                    end else begin
                        pcnt <= pcnt - 1'b1;
                    end
                end

                SET: begin
                    if (clr_req) begin
                        // Clear preempts set; never let both strobes be low together
                        state <= CLEAR;
                        H     <= 1'b1;
                        L     <= 1'b0;
                        pcnt  <= PCNT_MAX;
                    end else if (pcnt == '0) begin
                        state <= IDLE;
                        H     <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        pcnt <= pcnt - 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    E     <= 1'b0;
                    L     <= 1'b1;
                    H     <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrlset_gen.sv
// tb/tb_ctrlset_gen.sv - self-checking bench for ctrlset_gen with a strobe-length reference model
module tb_ctrlset_gen;

    localparam int DIV   = 4;
    localparam int PULSE = 3;
`ifdef CTRLSET_GEN_SETQ_EN
    localparam bit Q_EN = 1'b1;
`else
    localparam bit Q_EN = 1'b0;
`endif

    logic clk;
    logic R;
    logic run;
    logic clr_req;
    logic set_req;
    logic E;
    logic L;
    logic H;
    logic busy;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining low cycles of each strobe and run edges seen since last phase reset
    int m_clr_left = PULSE;
    int m_set_left = 0;
    int m_runs     = 0;
    bit m_pend     = 1'b0;
    bit m_e        = 1'b0;

    ctrlset_gen #(.DIV(DIV), .PULSE(PULSE)) dut (
        .clk     (clk),
        .R       (R),
        .run     (run),
        .clr_req (clr_req),
        .set_req (set_req),
        .E       (E),
        .L       (L),
        .H       (H),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model update on each edge (or immediately on reset assertion)
    always @(posedge clk or posedge R) begin
        if (R) begin
            m_clr_left = PULSE;
            m_set_left = 0;
            m_runs     = 0;
            m_pend     = 1'b0;
            m_e        = 1'b0;
        end else begin
            m_e = 1'b0;
            if (m_clr_left > 0) begin
                if (Q_EN && set_req) m_pend = 1'b1;
                if (clr_req) begin
                    m_clr_left = PULSE;
                end else begin
                    m_clr_left = m_clr_left - 1;
                    if (m_clr_left == 0 && m_pend) begin
                        m_set_left = PULSE;
                        m_pend     = 1'b0;
                    end
                end
            end else if (m_set_left > 0) begin
                if (clr_req) begin
                    m_set_left = 0;
                    m_clr_left = PULSE;
                end else begin
                    m_set_left = m_set_left - 1;
                end
            end else begin
                if (clr_req) begin
                    m_clr_left = PULSE;
                    m_runs     = 0;
                end else if (set_req) begin
                    m_set_left = PULSE;
                    m_runs     = 0;
                end else if (run) begin
                    m_runs = m_runs + 1;
                    if (m_runs == DIV) begin
                        m_e    = 1'b1;
                        m_runs = 0;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("E_model", E, m_e);
        check("L_model", L, (m_clr_left == 0));
        check("H_model", H, (m_set_left == 0));
        check("busy_model", busy, (m_clr_left > 0) || (m_set_left > 0));
        check("inv_e_gated", E & (~L | ~H), 1'b0);
        check("inv_lh_excl", ~L & ~H, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_E"}, E, 1'b0);
        check({tag, "_L"}, L, 1'b0);
        check({tag, "_H"}, H, 1'b1);
        check({tag, "_busy"}, busy, 1'b1);
    endtask

    initial begin
        R       = 1'b1;
        run     = 1'b0;
        clr_req = 1'b0;
        set_req = 1'b0;

        // Reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("rst_hold");
            compare_all();
        end

        // Release: L stays low for exactly PULSE edges
        R = 1'b0;
        for (int i = 1; i <= PULSE; i++) begin
            step();
            check("rst_release_L", L, (i == PULSE));
        end

        // Continuous run: E on every DIV-th edge
        run = 1'b1;
        for (int i = 1; i <= 3 * DIV; i++) begin
            step();
            check("div_E", E, (i % DIV) == 0);
        end

        // Two run edges, two idle gaps, two more: E on the DIV-th run edge only
        for (int i = 1; i <= 6; i++) begin
            run = (i == 3 || i == 4) ? 1'b0 : 1'b1;
            step();
            check("gap_E", E, (i == 6));
        end
        run = 1'b0;
        step();

        // Simultaneous requests: clear only
        clr_req = 1'b1;
        set_req = 1'b1;
        step();
        clr_req = 1'b0;
        set_req = 1'b0;
        for (int i = 1; i <= PULSE; i++) begin
            check("simul_L", L, 1'b0);
            check("simul_H", H, 1'b1);
            step();
        end
        check("simul_L_end", L, 1'b1);
        check("simul_busy_end", busy, 1'b0);

        // Set strobe preempted by clear on its second cycle
        set_req = 1'b1;
        step();
        set_req = 1'b0;
        check("pre_H_low", H, 1'b0);
        step();
        check("pre_H_low2", H, 1'b0);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        check("pre_H_rise", H, 1'b1);
        check("pre_L_fall", L, 1'b0);
        for (int i = 1; i < PULSE; i++) begin
            step();
            check("pre_L_low", L, 1'b0);
        end
        step();
        check("pre_L_end", L, 1'b1);

        // Set request during clear: queued with the macro, dropped without
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        set_req = 1'b1;
        step();
        set_req = 1'b0;
        for (int i = 2; i < PULSE; i++) step();
        step();
        check("q_L_rise", L, 1'b1);
        check("q_H", H, Q_EN ? 1'b0 : 1'b1);
        check("q_busy", busy, Q_EN);
        for (int i = 1; i <= PULSE; i++) step();
        check("q_H_end", H, 1'b1);
        check("q_busy_end", busy, 1'b0);

        // Asynchronous reset between edges in the middle of a set strobe
        set_req = 1'b1;
        step();
        set_req = 1'b0;
        check("async_pre_H", H, 1'b0);
        R = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        compare_all();
        @(negedge clk);
        R = 1'b0;
        for (int i = 0; i <= PULSE; i++) step();

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            run     = ($urandom_range(3, 0) != 0);
            clr_req = ($urandom_range(9, 0) == 0);
            set_req = ($urandom_range(7, 0) == 0);
            R       = ($urandom_range(99, 0) == 0);
            step();
        end
        R       = 1'b0;
        clr_req = 1'b0;
        set_req = 1'b0;
        repeat (PULSE + 2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
